// File: rtl/rca_lsq_scheduler_pkg.sv
// Shared types for the RCA load/store queue: platform widths, queue entry and scheduler states.
// rca_base stands in for the platform-wide parameters that rca_config builds on.
package rca_base;
   localparam int XLEN          = 32;
   localparam int GRID_NUM_ROWS = 4;
endpackage

package rca_config;
   import rca_base::*;

   localparam int ROW_W = $clog2(GRID_NUM_ROWS);

   typedef struct packed {
      logic [ROW_W-1:0] row;
      logic [XLEN-1:0]  addr;
      logic [XLEN-1:0]  data;
      logic [2:0]       fn3;
      logic             load;
      logic             store;
   } rca_lsq_entry_t;

   typedef enum logic [1:0] {
      LSQ_IDLE      = 2'd0,
      LSQ_ISSUE     = 2'd1,
      LSQ_WAIT_LOAD = 2'd2
   } lsq_state_t;
endpackage

// File: rtl/rca_lsq_scheduler_if.sv
// Grid-side and LSU-side bundles of the load/store queue.
// The lsq modports are the scheduler's view of each bundle.
interface rca_lsq_grid_interface;
   import rca_base::*;
   logic [XLEN-1:0]          addr [GRID_NUM_ROWS];
   logic [XLEN-1:0]          data [GRID_NUM_ROWS];
   logic [2:0]               fn3  [GRID_NUM_ROWS];
   logic [GRID_NUM_ROWS-1:0] load;
   logic [GRID_NUM_ROWS-1:0] store;
   logic [GRID_NUM_ROWS-1:0] new_request;
   logic                     fifo_full;
   logic [GRID_NUM_ROWS-1:0] load_complete;
   logic [XLEN-1:0]          load_data;

   modport lsq  (input addr, data, fn3, load, store, new_request,
                 output fifo_full, load_complete, load_data);
   modport grid (output addr, data, fn3, load, store, new_request,
                 input fifo_full, load_complete, load_data);
endinterface

interface rca_lsu_interface;
   import rca_base::*;
   logic [XLEN-1:0] rs1;
   logic [XLEN-1:0] rs2;
   logic [2:0]      fn3;
   logic            load;
   logic            store;
   logic            rca_lsu_lock;
   logic            lsu_ready;
   logic            load_complete;
   logic [XLEN-1:0] load_data;

   modport lsq (output rs1, rs2, fn3, load, store, rca_lsu_lock,
                input lsu_ready, load_complete, load_data);
   modport lsu (input rs1, rs2, fn3, load, store, rca_lsu_lock,
                output lsu_ready, load_complete, load_data);
endinterface

// File: rtl/rca_lsq_fifo.sv
// Request FIFO: up to NPUSH pushes (compacted in ascending index order) and one pop per cycle.
// Head visible combinationally; full is registered and leaves room for a whole row burst.
module rca_lsq_fifo
   import rca_base::*;
   import rca_config::*;
#(
   parameter int DEPTH = 8,
   parameter int NPUSH = GRID_NUM_ROWS
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NPUSH-1:0]       push_vld,
   input  rca_lsq_entry_t         push_dat [NPUSH],
   input  logic                   pop,
   output rca_lsq_entry_t         head_dat,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count_nxt,
   output logic                   full
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   rca_lsq_entry_t   mem_q [DEPTH];
   rca_lsq_entry_t   mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, slot;
   logic [CNT_W-1:0] count_q, count_d, free, n_acc, n_req;
   logic             full_q, full_d, do_pop;

   assign free   = CNT_W'(DEPTH) - count_q;
   assign do_pop = pop && (count_q != '0);

   always_comb begin
      mem_d = mem_q;
      n_acc = '0;
      n_req = '0;
      slot  = wr_ptr_q;
      for (int i = 0; i < NPUSH; i++) begin
         if (push_vld[i]) begin
            n_req = n_req + CNT_W'(1);
            // Requests beyond the free space are dropped, never wrapped onto live entries.
            if (n_acc < free) begin
               slot        = wr_ptr_q + n_acc[PTR_W-1:0];
               mem_d[slot] = push_dat[i];
               n_acc       = n_acc + CNT_W'(1);
            end
         end
      end
      wr_ptr_d = wr_ptr_q + n_acc[PTR_W-1:0];
      rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
      count_d  = count_q + n_acc - CNT_W'(do_pop);
      full_d   = (CNT_W'(DEPTH) - count_d) < CNT_W'(GRID_NUM_ROWS);
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
      end
   end

   overflow_chk: assert property (@(posedge clk) disable iff (!rst) n_req <= free);

   assign head_dat  = mem_q[rd_ptr_q];
   assign empty     = (count_q == '0);
   assign count_nxt = count_d;
   assign full      = full_q;
endmodule

// File: rtl/rca_lsq_scheduler.sv
// Queues grid row requests in row order and issues them one at a time to the LSU (1 cycle min latency).
// Holds the head while lsu_ready is low; a load blocks further issue until its completion returns.
module rca_lsq_scheduler
   import rca_base::*;
   import rca_config::*;
#(
   parameter int FIFO_DEPTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   rca_lsq_grid_interface.lsq grid,
   rca_lsu_interface.lsq      lsu,
   output logic              busy
);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   lsq_state_t               state_q, state_d;
   logic [ROW_W-1:0]         load_row_q, load_row_d;
   logic [GRID_NUM_ROWS-1:0] load_complete_q, load_complete_d;
   logic [XLEN-1:0]          load_data_q, load_data_d;
   rca_lsq_entry_t           push_dat [GRID_NUM_ROWS];
   rca_lsq_entry_t           head;
   logic                     empty, fifo_full, issue, lsu_load, lsu_store, lock;
   logic [CNT_W-1:0]         count_nxt;

   always_comb begin
      for (int r = 0; r < GRID_NUM_ROWS; r++) begin
         push_dat[r].row   = ROW_W'(r);
         push_dat[r].addr  = grid.addr[r];
         push_dat[r].data  = grid.data[r];
         push_dat[r].fn3   = grid.fn3[r];
         push_dat[r].load  = grid.load[r];
         push_dat[r].store = grid.store[r];
      end
   end

   rca_lsq_fifo #(.DEPTH(FIFO_DEPTH), .NPUSH(GRID_NUM_ROWS)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push_vld  (grid.new_request),
      .push_dat  (push_dat),
      .pop       (issue),
      .head_dat  (head),
      .empty     (empty),
      .count_nxt (count_nxt),
      .full      (fifo_full)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q         <= LSQ_IDLE;
         load_row_q      <= '0;
         load_complete_q <= '0;
         load_data_q     <= '0;
      end else begin
         state_q         <= state_d;
         load_row_q      <= load_row_d;
         load_complete_q <= load_complete_d;
         load_data_q     <= load_data_d;
      end
   end

   // Leaving IDLE on count_nxt lets a request issue the cycle after it arrives.
   always_comb begin
      state_d         = state_q;
      load_row_d      = load_row_q;
      load_complete_d = '0;
      load_data_d     = load_data_q;
      case (state_q)
         LSQ_IDLE: begin
            if (count_nxt != '0) state_d = LSQ_ISSUE;
         end
         LSQ_ISSUE: begin
            if (issue && head.load) begin
               state_d    = LSQ_WAIT_LOAD;
               load_row_d = head.row;
            end else if (count_nxt == '0) begin
               state_d = LSQ_IDLE;
            end
         end
         LSQ_WAIT_LOAD: begin
            if (lsu.load_complete) begin
               state_d                     = LSQ_IDLE;
               load_complete_d[load_row_q] = 1'b1;
               load_data_d                 = lsu.load_data;
            end
         end
         default: state_d = LSQ_IDLE;
      endcase
   end

   always_comb begin
      issue     = (state_q == LSQ_ISSUE) && !empty && lsu.lsu_ready;
      lsu_load  = issue && head.load;
      lsu_store = issue && head.store;
      lock      = !empty || (state_q != LSQ_IDLE);
   end

   assign lsu.rs1            = head.addr;
   assign lsu.rs2            = head.data;
   assign lsu.fn3            = head.fn3;
   assign lsu.load           = lsu_load;
   assign lsu.store          = lsu_store;
   assign lsu.rca_lsu_lock   = lock;
   assign grid.fifo_full     = fifo_full;
   assign grid.load_complete = load_complete_q;
   assign grid.load_data     = load_data_q;
   assign busy               = lock;
endmodule

// File: tb/tb_rca_lsq_scheduler.sv
// Directed bench for rca_lsq_scheduler: a queue-level model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_rca_lsq_scheduler;
   import rca_base::*;

   localparam int DEPTH = 8;
   localparam int ROWS  = GRID_NUM_ROWS;

   logic clk = 1'b0;
   logic rst;
   logic busy;

   always #5 clk = ~clk;

   rca_lsq_grid_interface g ();
   rca_lsu_interface      l ();

   rca_lsq_scheduler #(.FIFO_DEPTH(DEPTH)) dut (
      .clk  (clk),
      .rst  (rst),
      .grid (g),
      .lsu  (l),
      .busy (busy)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: requests queued in the order the grid must see them issued.
   typedef struct {
      int          row;
      logic [31:0] addr;
      logic [31:0] data;
      logic [2:0]  fn3;
      logic        ld;
      logic        st;
   } exp_t;

   exp_t        mq[$];
   bit          out_vld;
   int          out_row;
   bit          pend_vld;
   int          pend_row;
   logic [31:0] pend_data;
   int          n_issued = 0;

   always @(negedge clk) begin
      exp_t       e;
      bit         was_out;
      logic [3:0] exp_lc;
      if (!rst) begin
         mq.delete();
         out_vld  = 0;
         pend_vld = 0;
      end else begin
         was_out = out_vld;
         exp_lc  = '0;
         if (pend_vld) exp_lc[pend_row] = 1'b1;
         chk("m_load_complete", g.load_complete, exp_lc);
         if (pend_vld) chk("m_load_data", g.load_data, pend_data);
         pend_vld = 0;
         chk("m_lock", l.rca_lsu_lock, (mq.size() != 0) || was_out);
         chk("m_busy", busy, (mq.size() != 0) || was_out);
         chk("m_fifo_full", g.fifo_full, (DEPTH - mq.size()) < ROWS);
         if (was_out && l.load_complete) begin
            pend_vld  = 1;
            pend_row  = out_row;
            pend_data = l.load_data;
            out_vld   = 0;
         end
         if (l.load || l.store) begin
            chk("m_issue_onehot", l.load && l.store, 0);
            chk("m_issue_ready", l.lsu_ready, 1);
            chk("m_issue_while_load_out", was_out, 0);
            chk("m_issue_queued", mq.size() != 0, 1);
            if (mq.size() != 0) begin
               e = mq.pop_front();
               chk("m_rs1", l.rs1, e.addr);
               chk("m_rs2", l.rs2, e.data);
               chk("m_fn3", l.fn3, e.fn3);
               chk("m_kind", {l.load, l.store}, {e.ld, e.st});
               n_issued++;
               if (e.ld) begin
                  out_vld = 1;
                  out_row = e.row;
               end
            end
         end
         for (int r = 0; r < ROWS; r++) begin
            if (g.new_request[r]) begin
               e.row  = r;
               e.addr = g.addr[r];
               e.data = g.data[r];
               e.fn3  = g.fn3[r];
               e.ld   = g.load[r];
               e.st   = g.store[r];
               mq.push_back(e);
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_row(input int r, input logic [31:0] a, input logic [31:0] d,
                          input logic [2:0] f, input logic ld, input logic st);
      g.new_request[r] = 1'b1;
      g.addr[r]        = a;
      g.data[r]        = d;
      g.fn3[r]         = f;
      g.load[r]        = ld;
      g.store[r]       = st;
   endtask

   task automatic clear_req();
      g.new_request = '0;
      g.load        = '0;
      g.store       = '0;
   endtask

   task automatic wait_idle(input int budget);
      int k;
      k = 0;
      @(negedge clk);
      while (busy && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk("drain_idle", busy, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int total;
      int guard;
      int par;
      rst = 1'b1;
      clear_req();
      for (int r = 0; r < ROWS; r++) begin
         g.addr[r] = '0;
         g.data[r] = '0;
         g.fn3[r]  = '0;
      end
      l.lsu_ready     = 1'b1;
      l.load_complete = 1'b0;
      l.load_data     = '0;
      #2 rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_fifo_full", g.fifo_full, 0);
      chk("rst_load_complete", g.load_complete, 0);
      chk("rst_load_data", g.load_data, 0);
      chk("rst_load", l.load, 0);
      chk("rst_store", l.store, 0);
      chk("rst_lock", l.rca_lsu_lock, 0);
      chk("rst_busy", busy, 0);
      cyc();
      rst = 1'b1;

      // Single store, minimum latency
      cyc(); set_row(2, 32'h100, 32'hDEADBEEF, 3'd2, 1'b0, 1'b1);
      @(negedge clk); chk("t1_lock_before", l.rca_lsu_lock, 0);
      cyc(); clear_req();
      @(negedge clk);
      chk("t1_store", l.store, 1);
      chk("t1_rs1", l.rs1, 32'h100);
      chk("t1_rs2", l.rs2, 32'hDEADBEEF);
      chk("t1_fn3", l.fn3, 3'd2);
      cyc(); @(negedge clk);
      chk("t1_lock_after", l.rca_lsu_lock, 0);
      chk("t1_store_after", l.store, 0);

      // Rows 3, 0, 1 in one cycle issue as 0, 1, 3
      cyc();
      set_row(3, 32'h1030, 32'hA3, 3'd0, 1'b0, 1'b1);
      set_row(0, 32'h1000, 32'hA0, 3'd0, 1'b0, 1'b1);
      set_row(1, 32'h1010, 32'hA1, 3'd0, 1'b0, 1'b1);
      cyc(); clear_req();
      @(negedge clk); chk("t2_store0", l.store, 1); chk("t2_rs1_0", l.rs1, 32'h1000);
      cyc(); @(negedge clk); chk("t2_store1", l.store, 1); chk("t2_rs1_1", l.rs1, 32'h1010);
      cyc(); @(negedge clk); chk("t2_store3", l.store, 1); chk("t2_rs1_3", l.rs1, 32'h1030);
      cyc(); @(negedge clk); chk("t2_lock_after", l.rca_lsu_lock, 0);

      // Load on row 1, data returned three cycles after issue
      cyc(); set_row(1, 32'h200, 32'h0, 3'd2, 1'b1, 1'b0);
      cyc(); clear_req();
      @(negedge clk); chk("t3_load", l.load, 1); chk("t3_rs1", l.rs1, 32'h200);
      cyc();
      cyc();
      cyc(); l.load_complete = 1'b1; l.load_data = 32'h12345678;
      @(negedge clk); chk("t3_lc_early", g.load_complete, 4'b0000); chk("t3_lock_wait", l.rca_lsu_lock, 1);
      cyc(); l.load_complete = 1'b0; l.load_data = 32'h0;
      @(negedge clk);
      chk("t3_lc_pulse", g.load_complete, 4'b0010);
      chk("t3_load_data", g.load_data, 32'h12345678);
      chk("t3_lock_drop", l.rca_lsu_lock, 0);
      cyc(); @(negedge clk); chk("t3_lc_one_cycle", g.load_complete, 4'b0000);
      cyc(); l.load_complete = 1'b1; l.load_data = 32'hBAD;
      cyc(); l.load_complete = 1'b0; l.load_data = 32'h0;
      @(negedge clk); chk("t3_stray_ignored", g.load_complete, 4'b0000);

      // Backpressure with five queued stores
      cyc(); l.lsu_ready = 1'b0;
      for (int r = 0; r < ROWS; r++) set_row(r, 32'h3000 + 32'(r * 4), 32'(r), 3'd1, 1'b0, 1'b1);
      cyc(); clear_req();
      chk("t4_not_full_at_4", g.fifo_full, 0);
      set_row(0, 32'h3100, 32'h55, 3'd1, 1'b0, 1'b1);
      @(negedge clk); chk("t4_hold1", l.store, 0); chk("t4_head1", l.rs1, 32'h3000);
      cyc(); clear_req();
      @(negedge clk); chk("t4_full", g.fifo_full, 1); chk("t4_hold2", l.store, 0);
      cyc();
      cyc();
      cyc(); @(negedge clk); chk("t4_hold5", l.store, 0); chk("t4_head5", l.rs1, 32'h3000);
      cyc(); l.lsu_ready = 1'b1;
      @(negedge clk); chk("t4_release", l.store, 1); chk("t4_release_rs1", l.rs1, 32'h3000);
      cyc(); @(negedge clk); chk("t4_full_clears", g.fifo_full, 0); chk("t4_next_rs1", l.rs1, 32'h3004);
      wait_idle(50);

      // Continuous two-push / one-pop stream across three FIFO wraps
      total = 0;
      guard = 0;
      par   = 0;
      while (total < 3 * DEPTH && guard < 200) begin
         cyc(); clear_req();
         if (!g.fifo_full) begin
            set_row(par, 32'h4000 + 32'(total * 4), 32'(total), 3'(total), 1'b0, 1'b1);
            set_row(par + 2, 32'h4000 + 32'((total + 1) * 4), 32'(total + 1), 3'(total + 1), 1'b0, 1'b1);
            total += 2;
            par = 1 - par;
         end
         guard++;
      end
      cyc(); clear_req();
      wait_idle(100);
      chk("t5_issued_total", n_issued, 34);
      chk("t5_model_drained", mq.size(), 0);

      // Reset while a load is outstanding and a store is queued
      cyc(); set_row(3, 32'h500, 32'h0, 3'd2, 1'b1, 1'b0);
      cyc(); clear_req();
      @(negedge clk); chk("t6_load", l.load, 1);
      cyc(); set_row(0, 32'h600, 32'h66, 3'd2, 1'b0, 1'b1);
      cyc(); clear_req();
      @(negedge clk); chk("t6_wait_lock", l.rca_lsu_lock, 1); chk("t6_wait_no_issue", l.store, 0);
      cyc(); rst = 1'b0;
      #1;
      chk("t6_rst_lock", l.rca_lsu_lock, 0);
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_fifo_full", g.fifo_full, 0);
      chk("t6_rst_load", l.load, 0);
      chk("t6_rst_store", l.store, 0);
      chk("t6_rst_lc", g.load_complete, 0);
      chk("t6_rst_load_data", g.load_data, 0);
      cyc();
      cyc(); rst = 1'b1;
      cyc(); l.load_complete = 1'b1; l.load_data = 32'hCAFE;
      cyc(); l.load_complete = 1'b0; l.load_data = 32'h0;
      @(negedge clk);
      chk("t6_late_lc", g.load_complete, 0);
      chk("t6_late_data", g.load_data, 0);
      chk("t6_late_lock", l.rca_lsu_lock, 0);
      chk("t6_discarded_store", l.store, 0);
      repeat (3) cyc();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
